timer_multichannel: RTL

//  Parametrised multi-channel programmable timer for the I/O subsystem. Each channel has a

---
 rtl/timer_pkg.sv | 9 +
 rtl/timer_prescaler.sv | 23 ++
 rtl/timer_multichannel.sv | 79 +++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: cfg_data field positions, mode encodings and time-base count shared by the timer blocks
package timer_pkg;
    localparam int NUM_TB = 4;
    localparam int TB_LSB = 0;
    localparam int TB_MSB = 1;
    localparam int THR_LSB = 2;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider per time base; tick[b] pulses once every TB_DIVb clocks
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int TB_DIV0 = 1,
    parameter int TB_DIV1 = 10,
    parameter int TB_DIV2 = 100,
    parameter int TB_DIV3 = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [NUM_TB-1:0] tick
);
    localparam int CW = 16;
    for (genvar b = 0; b < NUM_TB; b++) begin : g_tb
        localparam int D = b == 0 ? TB_DIV0 : b == 1 ? TB_DIV1 : b == 2 ? TB_DIV2 : TB_DIV3;
        logic [CW-1:0] cnt;
        assign tick[b] = cnt == CW'(D - 1);
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) cnt <= '0;
            else cnt <= tick[b] ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/timer_multichannel.sv
// timer_multichannel: NUM_CH programmable one-shot/periodic timers sharing one prescaler,
// with sticky interrupt flags and combinational count readback
module timer_multichannel
    import timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int THRESH_W = 6,
    parameter int TB_DIV0  = 1,
    parameter int TB_DIV1  = 10,
    parameter int TB_DIV2  = 100,
    parameter int TB_DIV3  = 1000,
    localparam int SEL_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [THRESH_W+1:0] cfg_data,
    input  logic                cfg_periodic,
    input  logic [NUM_CH-1:0]   irq_ack,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [THRESH_W-1:0] rd_count,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   timer_end,
    output logic [NUM_CH-1:0]   irq_pending
);
    logic [NUM_TB-1:0] tick;
    logic [THRESH_W-1:0] counts [NUM_CH];
    logic [THRESH_W-1:0] cfg_thr;
    logic [1:0] cfg_tb;
    assign cfg_thr = cfg_data[THRESH_W+1:THR_LSB];
    assign cfg_tb = cfg_data[TB_MSB:TB_LSB];
    timer_prescaler #(
        .TB_DIV0(TB_DIV0),
        .TB_DIV1(TB_DIV1),
        .TB_DIV2(TB_DIV2),
        .TB_DIV3(TB_DIV3)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [THRESH_W-1:0] thr, cnt;
        logic [1:0] base;
        logic mode, run, pulse, flag, we, expire;
        assign we = cfg_we && cfg_sel == SEL_W'(i);
        assign expire = run && tick[base] && cnt == thr - 1'b1;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                thr <= '0;
                base <= '0;
                mode <= MODE_ONESHOT;
                cnt <= '0;
                run <= 1'b0;
                pulse <= 1'b0;
            end else if (we) begin
                thr <= cfg_thr;
                base <= cfg_tb;
                mode <= cfg_periodic;
                cnt <= '0;
                run <= |cfg_thr;
                pulse <= 1'b0;
            end else begin
                pulse <= expire;
                if (run && tick[base]) cnt <= expire ? '0 : cnt + 1'b1;
                if (expire && mode == MODE_ONESHOT) run <= 1'b0;
            end
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) flag <= 1'b0;
            else if (expire && !we) flag <= 1'b1;
            else if (irq_ack[i]) flag <= 1'b0;
        assign counts[i] = cnt;
        assign busy[i] = run;
        assign timer_end[i] = pulse;
        assign irq_pending[i] = flag;
    end
    assign rd_count = counts[rd_sel];
endmodule
